// File: rtl/cim_gemm_ctrl.sv
// cim_gemm_ctrl: job sequencer and sole command-bus master for the Basic_GeMM_CIM macro.
// Optional perf counters (perf_cycles/perf_stall) are built when CIM_GEMM_CTRL_PERF_EN is defined.
module cim_gemm_ctrl #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int N_OUT       = 8,
  parameter int IN_PER_ADDR = 2,
  parameter int ADDR_STEP   = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [3:0]    cfg_phase,
  input  logic [AW-1:0] cfg_w_src,
  input  logic [AW-1:0] cfg_w_dst,
  input  logic [15:0]   cfg_w_cnt,
  input  logic [AW-1:0] cfg_x_src,
  input  logic [AW-1:0] cfg_c_base,
  input  logic [15:0]   cfg_x_cnt,
  output logic          busy,
  output logic          done,
  output logic          buf_re,
  output logic [AW-1:0] buf_addr,
  input  logic [DW-1:0] buf_rdata,
  output logic          cim_cs,
  output logic          cim_write,
  output logic          cim_cim,
  output logic          cim_partial_sum,
  output logic          cim_reset_output,
  output logic [3:0]    cim_output_reg,
  output logic [AW-1:0] cim_address,
  output logic [DW-1:0] cim_input_data,
  input  logic [DW-1:0] cim_output,
  output logic          out_valid,
  output logic [3:0]    out_idx,
  output logic [DW-1:0] out_data,
  input  logic          out_ready
`ifdef CIM_GEMM_CTRL_PERF_EN
  ,
  output logic [31:0]   perf_cycles,
  output logic [31:0]   perf_stall
`endif
);
  localparam int STAGES = 1;
  localparam int SW     = (IN_PER_ADDR > 1) ? $clog2(IN_PER_ADDR) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_COMP, S_READ, S_CLR, S_DONE} state_t;

  typedef struct packed {
    logic [3:0]    phase;
    logic [AW-1:0] w_src;
    logic [AW-1:0] w_dst;
    logic [15:0]   w_cnt;
    logic [AW-1:0] x_src;
    logic [AW-1:0] c_base;
    logic [15:0]   x_cnt;
  } cfg_t;

  state_t          state, state_nx;
  cfg_t            cfg_q, cfg_in, cfg_src;
  logic [15:0]     rd_cnt, cur_cnt;
  logic [AW-1:0]   rd_addr, dst_addr, pend_addr, hold_addr;
  logic [DW-1:0]   hold_data, out_data_q;
  logic [SW-1:0]   sub_cnt;
  logic [STAGES:1] vld_pipe;
  logic [4:0]      ro_idx;
  logic            ro_wait, ro_first;
  logic            rd_fire, in_stream, stream_last, ro_last, ro_xfer;

  // First enabled, non-empty phase at or after position 'from' (0=LOAD .. 3=CLEAR).
  function automatic state_t pick(input cfg_t c, input int from);
    state_t r;
    r = S_DONE;
    if (from <= 3 && c.phase[3]) r = S_CLR;
    if (from <= 2 && c.phase[2]) r = S_READ;
    if (from <= 1 && c.phase[1] && c.x_cnt != 16'd0) r = S_COMP;
    if (from <= 0 && c.phase[0] && c.w_cnt != 16'd0) r = S_LOAD;
    return r;
  endfunction

  always_comb begin
    cfg_in.phase  = cfg_phase;
    cfg_in.w_src  = cfg_w_src;
    cfg_in.w_dst  = cfg_w_dst;
    cfg_in.w_cnt  = cfg_w_cnt;
    cfg_in.x_src  = cfg_x_src;
    cfg_in.c_base = cfg_c_base;
    cfg_in.x_cnt  = cfg_x_cnt;
    // Phase-entry decisions out of IDLE must see the config being latched this cycle.
    cfg_src = (state == S_IDLE) ? cfg_in : cfg_q;
  end

  assign in_stream   = (state == S_LOAD) || (state == S_COMP);
  assign cur_cnt     = (state == S_LOAD) ? cfg_q.w_cnt : cfg_q.x_cnt;
  assign rd_fire     = in_stream && (rd_cnt != cur_cnt);
  assign stream_last = in_stream && !rd_fire;
  assign ro_last     = (ro_idx == 5'(N_OUT-1));
  assign ro_xfer     = (state == S_READ) && ro_wait && out_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (start)             state_nx = pick(cfg_src, 0);
      S_LOAD:  if (stream_last)       state_nx = pick(cfg_src, 1);
      S_COMP:  if (stream_last)       state_nx = pick(cfg_src, 2);
      S_READ:  if (ro_xfer && ro_last) state_nx = pick(cfg_src, 3);
      S_CLR:   if (ro_last)           state_nx = pick(cfg_src, 4);
      S_DONE:                         state_nx = S_IDLE;
      default:                        state_nx = S_IDLE;
    endcase
  end

  // Datapath: read pipeline, address walkers, readout handshake, held bus values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_q      <= '0;
      rd_cnt     <= '0;
      rd_addr    <= '0;
      dst_addr   <= '0;
      pend_addr  <= '0;
      sub_cnt    <= '0;
      vld_pipe   <= '0;
      hold_addr  <= '0;
      hold_data  <= '0;
      out_data_q <= '0;
      ro_idx     <= '0;
      ro_wait    <= 1'b0;
      ro_first   <= 1'b0;
    end else begin
      if (state == S_IDLE && start) cfg_q <= cfg_in;

      vld_pipe[1] <= rd_fire;
      if (rd_fire) begin
        rd_cnt    <= rd_cnt + 16'd1;
        rd_addr   <= rd_addr + AW'(4);
        pend_addr <= dst_addr;
        if (state == S_LOAD) begin
          dst_addr <= dst_addr + AW'(4);
        end else if (sub_cnt == SW'(IN_PER_ADDR-1)) begin
          sub_cnt  <= '0;
          dst_addr <= dst_addr + AW'(ADDR_STEP);
        end else begin
          sub_cnt  <= sub_cnt + SW'(1);
        end
      end

      if (in_stream && vld_pipe[STAGES]) begin
        hold_addr <= pend_addr;
        hold_data <= buf_rdata;
      end

      // Readout: issue cycle (ro_wait=0), then valid cycles until accepted.
      if (state == S_READ) begin
        if (!ro_wait) begin
          ro_wait  <= 1'b1;
          ro_first <= 1'b1;
        end else begin
          ro_first <= 1'b0;
          if (ro_first) out_data_q <= cim_output;
          if (out_ready) begin
            ro_wait <= 1'b0;
            ro_idx  <= ro_idx + 5'd1;
          end
        end
      end
      if (state == S_CLR) ro_idx <= ro_idx + 5'd1;

      if (state_nx != state) begin
        rd_cnt   <= '0;
        sub_cnt  <= '0;
        ro_idx   <= '0;
        ro_wait  <= 1'b0;
        ro_first <= 1'b0;
        if (state_nx == S_LOAD) begin
          rd_addr  <= cfg_src.w_src;
          dst_addr <= cfg_src.w_dst;
        end else if (state_nx == S_COMP) begin
          rd_addr  <= cfg_src.x_src;
          dst_addr <= cfg_src.c_base;
        end
      end
    end
  end

  // Outputs
  always_comb begin
    busy             = (state != S_IDLE);
    done             = (state == S_DONE);
    buf_re           = rd_fire;
    buf_addr         = rd_addr;
    cim_cs           = 1'b0;
    cim_write        = 1'b0;
    cim_cim          = 1'b0;
    cim_partial_sum  = 1'b0;
    cim_reset_output = 1'b0;
    cim_output_reg   = '0;
    cim_address      = hold_addr;
    cim_input_data   = hold_data;
    out_valid        = (state == S_READ) && ro_wait;
    out_idx          = (state == S_READ) ? ro_idx[3:0] : 4'd0;
    // Result is live from the macro on its first valid cycle, then held locally.
    out_data         = (state == S_READ && ro_first) ? cim_output : out_data_q;
    unique case (state)
      S_LOAD: if (vld_pipe[STAGES]) begin
        cim_cs         = 1'b1;
        cim_write      = 1'b1;
        cim_address    = pend_addr;
        cim_input_data = buf_rdata;
      end
      S_COMP: if (vld_pipe[STAGES]) begin
        cim_cs          = 1'b1;
        cim_cim         = 1'b1;
        cim_partial_sum = 1'b1;
        cim_address     = pend_addr;
        cim_input_data  = buf_rdata;
      end
      S_READ: begin
        cim_cs         = 1'b1;
        cim_cim        = 1'b1;
        cim_output_reg = ro_idx[3:0];
      end
      S_CLR: begin
        cim_cs           = 1'b1;
        cim_cim          = 1'b1;
        cim_reset_output = 1'b1;
        cim_output_reg   = ro_idx[3:0];
      end
      default: ;
    endcase
  end

`ifdef CIM_GEMM_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cycles <= '0;
      perf_stall  <= '0;
    end else if (state == S_IDLE && start) begin
      perf_cycles <= '0;
      perf_stall  <= '0;
    end else begin
      if (busy) perf_cycles <= perf_cycles + 32'd1;
      if (state == S_READ && ro_wait && !out_ready) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cim_gemm_ctrl.sv
// Directed bench for cim_gemm_ctrl with a registered buffer model, a CIM output-register
// model, and a negedge monitor that logs command-bus traffic and handshakes.
module tb_cim_gemm_ctrl;
  localparam int AW = 32;
  localparam int DW = 32;

  typedef struct packed {
    logic [31:0] c;
    logic [31:0] a;
    logic [31:0] d;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [3:0]    cfg_phase = '0;
  logic [AW-1:0] cfg_w_src = '0, cfg_w_dst = '0, cfg_x_src = '0, cfg_c_base = '0;
  logic [15:0]   cfg_w_cnt = '0, cfg_x_cnt = '0;
  logic          busy, done, buf_re;
  logic [AW-1:0] buf_addr;
  logic [DW-1:0] buf_rdata = '0;
  logic          cim_cs, cim_write, cim_cim, cim_partial_sum, cim_reset_output;
  logic [3:0]    cim_output_reg;
  logic [AW-1:0] cim_address;
  logic [DW-1:0] cim_input_data;
  logic [DW-1:0] cim_output = '0;
  logic          out_valid;
  logic [3:0]    out_idx;
  logic [DW-1:0] out_data;
  logic          out_ready = 1'b1;
`ifdef CIM_GEMM_CTRL_PERF_EN
  logic [31:0]   perf_cycles, perf_stall;
`endif

  cim_gemm_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .cfg_phase(cfg_phase),
    .cfg_w_src(cfg_w_src), .cfg_w_dst(cfg_w_dst), .cfg_w_cnt(cfg_w_cnt),
    .cfg_x_src(cfg_x_src), .cfg_c_base(cfg_c_base), .cfg_x_cnt(cfg_x_cnt),
    .busy(busy), .done(done), .buf_re(buf_re), .buf_addr(buf_addr), .buf_rdata(buf_rdata),
    .cim_cs(cim_cs), .cim_write(cim_write), .cim_cim(cim_cim),
    .cim_partial_sum(cim_partial_sum), .cim_reset_output(cim_reset_output),
    .cim_output_reg(cim_output_reg), .cim_address(cim_address),
    .cim_input_data(cim_input_data), .cim_output(cim_output),
    .out_valid(out_valid), .out_idx(out_idx), .out_data(out_data), .out_ready(out_ready)
`ifdef CIM_GEMM_CTRL_PERF_EN
    , .perf_cycles(perf_cycles), .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Operand buffer and CIM output-register models
  logic [DW-1:0] bmem [0:255];
  logic [DW-1:0] acc  [0:15];
  always @(posedge clk) begin
    if (buf_re) buf_rdata <= bmem[buf_addr[9:2]];
    if (cim_cs && cim_cim && !cim_partial_sum && !cim_reset_output) cim_output <= acc[cim_output_reg];
    if (cim_cs && cim_cim && cim_reset_output) acc[cim_output_reg] <= '0;
  end

  ev_t  wr_q[$], mac_q[$], clr_q[$], rd_q[$];
  int   n_done, done_cyc, n_busy, n_stall, n_unstable, n_illegal = 0;
  int   stall_idx = -1, stall_left = 0;
  logic [15:0] kind_code;
  logic [3:0]  last_kind;
  logic        pend = 1'b0;
  logic [DW-1:0] ref_d;
  logic [3:0]  ref_r, ref_i;

  always @(negedge clk) begin
    logic [3:0] kind;
    if (out_valid && stall_left > 0 && int'(out_idx) == stall_idx) begin
      out_ready = 1'b0;
      stall_left--;
      n_stall++;
    end else begin
      out_ready = 1'b1;
    end
    if (out_valid) begin
      if (pend) begin
        if (out_data !== ref_d || cim_output_reg !== ref_r || out_idx !== ref_i || cim_cs !== 1'b1)
          n_unstable++;
      end else begin
        ref_d = out_data; ref_r = cim_output_reg; ref_i = out_idx;
      end
      pend = !out_ready;
      if (out_ready) rd_q.push_back({32'(cyc), 28'd0, out_idx, out_data});
    end
    kind = 4'd0;
    if (cim_cs && cim_write) begin
      kind = 4'd1; wr_q.push_back({32'(cyc), cim_address, cim_input_data});
    end
    if (cim_cs && cim_cim && cim_partial_sum) begin
      kind = 4'd2; mac_q.push_back({32'(cyc), cim_address, cim_input_data});
    end
    if (cim_cs && cim_cim && !cim_partial_sum && !cim_reset_output) kind = 4'd3;
    if (cim_cs && cim_cim && cim_reset_output) begin
      kind = 4'd4; clr_q.push_back({32'(cyc), 28'd0, cim_output_reg, 32'd0});
    end
    if (cim_write && cim_cim) n_illegal++;
    if (!cim_cs && (cim_write || cim_cim || cim_partial_sum || cim_reset_output)) n_illegal++;
    if (kind != 4'd0 && kind != last_kind) begin
      kind_code = {kind_code[11:0], kind};
      last_kind = kind;
    end
    if (done) begin n_done++; done_cyc = cyc; end
    if (busy) n_busy++;
  end

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr_logs();
    wr_q.delete(); mac_q.delete(); clr_q.delete(); rd_q.delete();
    n_done = 0; done_cyc = -1; n_busy = 0; n_stall = 0; n_unstable = 0;
    kind_code = '0; last_kind = '0; pend = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int t = 0;
    while (n_done == 0 && t < budget) begin
      @(posedge clk); #1;
      t++;
    end
  endtask

  // Returns done latency in cycles after the start cycle, or -1 on timeout.
  task automatic run_job(input logic [3:0] ph, input logic [31:0] ws, input logic [31:0] wd,
                         input logic [15:0] wc, input logic [31:0] xs, input logic [31:0] cb,
                         input logic [15:0] xc, output int lat);
    int s;
    clr_logs();
    cfg_phase = ph; cfg_w_src = ws; cfg_w_dst = wd; cfg_w_cnt = wc;
    cfg_x_src = xs; cfg_c_base = cb; cfg_x_cnt = xc;
    start = 1'b1; s = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(300);
    lat = (n_done != 0) ? done_cyc - s : -1;
    repeat (2) @(posedge clk); #1;
  endtask

  logic [31:0] ld_exp [0:3];
  logic [31:0] mc_exp [0:3];

  initial begin
    int  lat, s;
    ev_t ev, ev0;
    for (int i = 0; i < 256; i++) bmem[i] = 32'h0;
    ld_exp[0] = 32'h33221100; ld_exp[1] = 32'h00112233;
    ld_exp[2] = 32'h33221100; ld_exp[3] = 32'h00112233;
    mc_exp[0] = 32'h33333333; mc_exp[1] = 32'h44444444;
    mc_exp[2] = 32'h55555555; mc_exp[3] = 32'h66666666;
    for (int i = 0; i < 4; i++) begin
      bmem[64+i]  = ld_exp[i];
      bmem[128+i] = mc_exp[i];
      bmem[132+i] = 32'h77770000 + 32'(i);
    end
    for (int i = 0; i < 16; i++) acc[i] = 32'hA0 + 32'(i);
    clr_logs();

    repeat (3) @(posedge clk); #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cs", cim_cs, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_buf_re", buf_re, 0);
    chk("rst_cim_addr", cim_address, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Weight load
    run_job(4'b0001, 32'h100, 32'h0, 16'd4, 32'h0, 32'h0, 16'd0, lat);
    chk("ld_latency", lat, 6);
    chk("ld_busy_cycles", n_busy, 6);
    chk("ld_count", wr_q.size(), 4);
    chk("ld_no_mac", mac_q.size(), 0);
    for (int i = 0; i < 4; i++) begin
      ev = (i < wr_q.size()) ? wr_q[i] : '0;
      chk("ld_addr", ev.a, 64'(4*i));
      chk("ld_data", ev.d, ld_exp[i]);
    end
    ev0 = (wr_q.size() > 0) ? wr_q[0] : '0;
    ev  = (wr_q.size() > 3) ? wr_q[3] : '0;
    chk("ld_consecutive", ev.c - ev0.c, 3);

    // Compute
    run_job(4'b0010, 32'h0, 32'h0, 16'd0, 32'h200, 32'h0, 16'd4, lat);
    chk("mac_latency", lat, 6);
    chk("mac_count", mac_q.size(), 4);
    chk("mac_no_write", wr_q.size(), 0);
    for (int i = 0; i < 4; i++) begin
      ev = (i < mac_q.size()) ? mac_q[i] : '0;
      chk("mac_addr", ev.a, (i < 2) ? 64'h0 : 64'h8);
      chk("mac_data", ev.d, mc_exp[i]);
    end
    ev0 = (mac_q.size() > 0) ? mac_q[0] : '0;
    ev  = (mac_q.size() > 3) ? mac_q[3] : '0;
    chk("mac_consecutive", ev.c - ev0.c, 3);

    // Readout with a 3-cycle stall on index 2
    stall_idx = 2; stall_left = 3;
    run_job(4'b0100, 32'h0, 32'h0, 16'd0, 32'h0, 32'h0, 16'd0, lat);
    chk("ro_latency", lat, 20);
    chk("ro_count", rd_q.size(), 8);
    chk("ro_stalls", n_stall, 3);
    chk("ro_stable", n_unstable, 0);
    for (int i = 0; i < 8; i++) begin
      ev = (i < rd_q.size()) ? rd_q[i] : '0;
      chk("ro_idx", ev.a, 64'(i));
      chk("ro_data", ev.d, 64'h0A0 + 64'(i));
    end

    // Full job with stall
    stall_idx = 2; stall_left = 3;
    run_job(4'b1111, 32'h100, 32'h40, 16'd4, 32'h200, 32'h80, 16'd4, lat);
    chk("full_latency", lat, 38);
    chk("full_busy_cycles", n_busy, 38);
    chk("full_phase_order", kind_code, 16'h1234);
    ev = (wr_q.size() > 0) ? wr_q[0] : '0;
    chk("full_w_addr0", ev.a, 32'h40);
    ev = (mac_q.size() > 3) ? mac_q[3] : '0;
    chk("full_mac_addr3", ev.a, 32'h88);
    ev = (rd_q.size() > 7) ? rd_q[7] : '0;
    chk("full_ro_data7", ev.d, 32'hA7);
    chk("full_clr_count", clr_q.size(), 8);
    for (int i = 0; i < 8; i++) begin
      ev = (i < clr_q.size()) ? clr_q[i] : '0;
      chk("full_clr_reg", ev.a, 64'(i));
    end
`ifdef CIM_GEMM_CTRL_PERF_EN
    chk("perf_stall", perf_stall, 3);
    chk("perf_cycles", perf_cycles, 38);
`endif

    // Readout after clear returns zeros
    run_job(4'b0100, 32'h0, 32'h0, 16'd0, 32'h0, 32'h0, 16'd0, lat);
    chk("zero_latency", lat, 17);
    chk("zero_count", rd_q.size(), 8);
    for (int i = 0; i < 8; i++) begin
      ev = (i < rd_q.size()) ? rd_q[i] : '1;
      chk("zero_data", ev.d, 0);
    end

    // Start while busy is ignored; config changes after acceptance have no effect
    clr_logs();
    cfg_phase = 4'b0001; cfg_w_src = 32'h100; cfg_w_dst = 32'h0; cfg_w_cnt = 16'd4;
    start = 1'b1; s = cyc;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    cfg_phase = 4'b0010; cfg_w_dst = 32'h500; cfg_x_src = 32'h200; cfg_x_cnt = 16'd4; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_done(100);
    lat = (n_done != 0) ? done_cyc - s : -1;
    repeat (10) @(posedge clk); #1;
    chk("rs_latency", lat, 6);
    chk("rs_done_count", n_done, 1);
    chk("rs_no_mac", mac_q.size(), 0);
    ev = (wr_q.size() > 0) ? wr_q[0] : '1;
    chk("rs_w_addr0", ev.a, 0);

    // Zero weight count skips LOAD_W
    run_job(4'b0011, 32'h100, 32'h0, 16'd0, 32'h200, 32'h10, 16'd2, lat);
    chk("skip_latency", lat, 4);
    chk("skip_no_write", wr_q.size(), 0);
    chk("skip_mac_count", mac_q.size(), 2);
    ev = (mac_q.size() > 1) ? mac_q[1] : '0;
    chk("skip_mac_addr1", ev.a, 32'h10);

    // No phases: one busy cycle that is also the done cycle
    run_job(4'b0000, 32'h0, 32'h0, 16'd0, 32'h0, 32'h0, 16'd0, lat);
    chk("empty_latency", lat, 1);
    chk("empty_busy_cycles", n_busy, 1);

    // Reset in the middle of COMPUTE
    clr_logs();
    cfg_phase = 4'b0010; cfg_x_src = 32'h200; cfg_c_base = 32'h0; cfg_x_cnt = 16'd8;
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_cs", cim_cs, 0);
    chk("mid_rst_cim", cim_cim, 0);
    chk("mid_rst_psum", cim_partial_sum, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_buf_re", buf_re, 0);
    rst = 1'b0;
    repeat (12) @(posedge clk); #1;
    chk("mid_rst_mac_count", mac_q.size(), 3);
    chk("mid_rst_no_done", n_done, 0);
    chk("illegal_cmds", n_illegal, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
